// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with an optional scan sequencer (DECODER_SEQ_SCAN_EN).
// Latency 1 cycle from en/mode/load/sel to out/idx/valid/wrap; no backpressure, free-running.
module decoder_seq #(
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  load,
    input  logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      idx,
    output logic                  valid,
    output logic                  wrap
);

    localparam int OUT_W = 2**SEL_W;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] idx_nxt;
    logic [OUT_W-1:0] out_nxt;
    logic             valid_nxt;
    logic             step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_OFF;
        if (en) begin
`ifdef DECODER_SEQ_SCAN_EN
            state_nxt = mode ? ST_SCAN : ST_DIRECT;
`else
            state_nxt = ST_DIRECT;
`endif
        end
    end

`ifdef DECODER_SEQ_SCAN_EN
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;
    logic             wrap_nxt;

    // The divider only runs while staying in SCAN; a load or any state change restarts it.
    always_comb begin
        step        = 1'b0;
        div_cnt_nxt = '0;
        if (state == ST_SCAN && state_nxt == ST_SCAN && !load) begin
            if (div_cnt == DIV_LAST) begin
                step = 1'b1;
            end else begin
                div_cnt_nxt = div_cnt + 1'b1;
            end
        end
    end

    assign wrap_nxt = step && (idx == {SEL_W{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            wrap    <= 1'b0;
        end else begin
            div_cnt <= div_cnt_nxt;
            wrap    <= wrap_nxt;
        end
    end
`else
    logic unused_cfg;

    assign step = 1'b0;
    assign wrap = 1'b0;
    // mode, SCAN_DIV and the SCAN encoding only matter when the sequencer is built.
    assign unused_cfg = mode ^ (SCAN_DIV == 0) ^ (state == ST_SCAN);
`endif

    always_comb begin
        idx_nxt = idx;
        if (load) begin
            idx_nxt = sel;
        end else if (step) begin
            idx_nxt = idx + 1'b1;
        end
        valid_nxt = (state_nxt != ST_OFF);
        out_nxt   = valid_nxt ? (OUT_W'(1) << idx_nxt) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            idx   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= out_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
        end
    end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised binary-to-one-hot decoder with a built-in scan sequencer. It generalises the fixed 3-to-8 gate decoder in two ways: select width is a parameter, and the one-hot output is registered. A scan mode walks the active line across all outputs at a programmable rate. It drives row/chip-select, mux-select and LED/keypad scan lines in the combinational-components library.

## Interface
Parameters:
- SEL_W, 3, select width; legal range 1..8. OUT_W = 2**SEL_W is derived and not overridable.
- SCAN_DIV, 1, number of clock cycles each line stays active in scan mode; legal range 1..65535.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  block enable; when low, all outputs are forced inactive.
- mode  input  1  0 = direct decode, 1 = scan.
- load  input  1  one-cycle strobe that captures sel.
- sel  input  SEL_W  binary index to decode or to start the scan from.
- out  output  OUT_W  registered one-hot output.
- idx  output  SEL_W  index currently decoded onto out.
- valid  output  1  high while out carries an active one-hot value.
- wrap  output  1  one-cycle pulse when the scan rolls from OUT_W-1 to 0.

## Operation
- Every output is registered.
- The state machine has three states, and the next state is evaluated every cycle:
  - OFF: entered when en=0.
  - DIRECT: entered when en=1 and mode=0.
  - SCAN: entered when en=1 and mode=1.
- out is always either all-zero or exactly one-hot, with out[idx] set. No other pattern is ever legal.
- In OFF:
  - out=0 and valid=0.
  - idx holds its value, but a load still updates idx.
  - The divider counter is cleared.
- In DIRECT:
  - load=1 sets idx to sel.
  - With no load, idx holds.
  - out=onehot(idx) and valid=1.
- In SCAN, a divider counter div_cnt counts 0..SCAN_DIV-1:
  - When div_cnt reaches SCAN_DIV-1, idx advances to idx+1 modulo OUT_W and div_cnt returns to 0.
  - out=onehot(idx) and valid=1.
  - wrap=1 for exactly the one cycle in which idx steps from OUT_W-1 to 0.
- A load in SCAN has priority over the step: idx becomes sel, div_cnt becomes 0, and wrap is not asserted.
- Any state change clears div_cnt. idx is never cleared by a state change.
- Arithmetic:
  - The index increment is SEL_W bits wide and wraps naturally.
  - div_cnt is clog2(SCAN_DIV) bits wide, with a minimum of 1 bit.
  - When SCAN_DIV=1, idx steps every cycle.

## Timing
- Reset (rst_n low) acts immediately, without waiting for clk. It forces:
  - out=0, idx=0, valid=0, wrap=0;
  - div_cnt=0;
  - the state machine to OFF.
- After rst_n rises, the first rising edge evaluates en and mode.
- Latency:
  - From en, mode, load or sel sampled at edge k, the result appears on out, idx and valid after edge k.
  - This is a latency of 1 cycle.
- Entering SCAN at edge k:
  - out shows the current idx for SCAN_DIV cycles.
  - The first step happens at edge k+SCAN_DIV.
- Load while en=0: idx is updated, out stays 0. When en rises, out shows onehot(sel) after 1 cycle.
- Simultaneous events:
  - Scan step and load on the same edge: load wins.
  - en falling on the same edge as a step: OFF wins; idx does not step and wrap stays 0.
- wrap is never high while valid=0.
- Reset asserted mid-scan aborts the scan immediately. Scanning resumes from idx=0 only after re-enable.

## Configuration
- Macro: DECODER_SEQ_SCAN_EN.
- Defined:
  - SCAN state, divider and wrap logic are compiled in, as described above.
- Undefined:
  - The mode input is ignored: en=1 always selects DIRECT.
  - wrap is tied to 0.
  - The divider is not instantiated and SCAN_DIV is unused.
  - Direct-decode behaviour and latency are unchanged.

## Test plan
- Reset value: assert rst_n=0 mid-cycle during a scan -> out=0, idx=0, valid=0 and wrap=0 immediately, without waiting for clk.
- Direct decode: SEL_W=3, en=1, mode=0, load pulses with sel=0..7 -> one cycle later out=8'b0000_0001 through 8'b1000_0000, idx=sel, valid=1. Repeat with SEL_W=4 and sel=15 -> out=16'h8000.
- Scan with divider: SEL_W=3, SCAN_DIV=3, load sel=6, then mode=1 -> idx sequence 6,6,6,7,7,7,0,… with wrap high only on the first cycle of idx=0. Each idx is held exactly 3 cycles.
- Load vs step collision: SCAN_DIV=1, drive a load of sel=2 on the edge where idx would wrap 7->0 -> next idx=2 and wrap=0.
- Disable/enable: during a scan at idx=5, drop en -> out=0 and valid=0 next cycle. While disabled, load sel=1, then raise en with mode=0 -> out=8'b0000_0010 one cycle later.
- Macro off: build without DECODER_SEQ_SCAN_EN and drive mode=1, en=1 -> idx holds and wrap stays 0 over 20 cycles.
